// File: rtl/digit_entry_pkg.sv
// Shared constants and helpers for the digit-entry register.
package digit_entry_pkg;

    localparam int BCD_MAX = 9;

    function automatic int count_width(input int num_digits);
        return $clog2(num_digits + 1);
    endfunction

endpackage

// File: rtl/digit_entry_reg_rise_edge_det.sv
// One-bit rising-edge detector; history clears on reset so a held input
// yields one event on the first cycle after reset releases.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic ev
);

    logic hist_q;

    always_ff @(posedge clk) begin
        if (rst) hist_q <= 1'b0;
        else     hist_q <= sig;
    end

    assign ev = sig & ~hist_q;

endmodule

// File: rtl/digit_entry_reg.sv
// Keypad digit-entry shift register with backspace, clear, load, digit count
// and refused-request pulse.
module digit_entry_reg
    import digit_entry_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int DIGIT_W    = 4,
    parameter  bit BCD_MODE   = 1'b0,
    parameter  bit OVERWRITE  = 1'b1,
    parameter  bit EDGE_DET   = 1'b1,
    localparam int W          = NUM_DIGITS * DIGIT_W,
    localparam int CW         = count_width(NUM_DIGITS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic [W-1:0]       load_val,
    output logic [W-1:0]       dato,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic               reject
);

    localparam logic [CW-1:0] COUNT_MAX = CW'(NUM_DIGITS);
    localparam logic [31:0]   BCD_LIM   = 32'(BCD_MAX);

    logic          push_ev;
    logic          pop_ev;
    logic [W-1:0]  dato_n;
    logic [CW-1:0] count_n;
    logic          reject_n;
    logic          bad_digit;

    generate
        if (EDGE_DET) begin : g_edge
            rise_edge_det u_push_det (.clk(clk), .rst(rst), .sig(push), .ev(push_ev));
            rise_edge_det u_pop_det  (.clk(clk), .rst(rst), .sig(pop),  .ev(pop_ev));
        end else begin : g_strobe
            assign push_ev = push;
            assign pop_ev  = pop;
        end
    endgenerate

    assign bad_digit = BCD_MODE && (32'(digit_in) > BCD_LIM);
    assign full      = (count == COUNT_MAX);
    assign empty     = (count == '0);

    // Shifts are written as shift/or so NUM_DIGITS = 1 needs no special case.
    always_comb begin
        dato_n   = dato;
        count_n  = count;
        reject_n = 1'b0;
        if (clr) begin
            dato_n  = '0;
            count_n = '0;
        end else if (load) begin
            dato_n  = load_val;
            count_n = COUNT_MAX;
        end else if (push_ev && pop_ev) begin
            reject_n = 1'b1;
        end else if (push_ev) begin
            if (bad_digit) begin
                reject_n = 1'b1;
            end else if (!full) begin
                dato_n  = (dato << DIGIT_W) | W'(digit_in);
                count_n = count + CW'(1);
            end else if (OVERWRITE) begin
                dato_n  = (dato << DIGIT_W) | W'(digit_in);
            end else begin
                reject_n = 1'b1;
            end
        end else if (pop_ev) begin
            if (empty) begin
                reject_n = 1'b1;
            end else begin
                dato_n  = dato >> DIGIT_W;
                count_n = count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dato   <= '0;
            count  <= '0;
            reject <= 1'b0;
        end else begin
            dato   <= dato_n;
            count  <= count_n;
            reject <= reject_n;
        end
    end

endmodule

// File: tb/tb_digit_entry_reg.sv
// Scoreboard bench: four configurations share one stimulus stream; expected
// results are queued per cycle and checked by an independent monitor.
module tb_digit_entry_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0, pop = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0]  digit_in = '0;
    logic [15:0] load_val = '0;

    logic [15:0] dato_o   [4];
    logic [2:0]  count_o  [4];
    logic        full_o   [4];
    logic        empty_o  [4];
    logic        reject_o [4];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          tag;
        int          dut;
        int          id;
        logic [15:0] dato;
        logic [2:0]  count;
        logic        reject;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: defaults, 1: OVERWRITE=0, 2: BCD_MODE=1, 3: EDGE_DET=0
    digit_entry_reg #(.NUM_DIGITS(4), .DIGIT_W(4), .BCD_MODE(1'b0), .OVERWRITE(1'b1), .EDGE_DET(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clr(clr), .load(load),
        .digit_in(digit_in), .load_val(load_val), .dato(dato_o[0]), .count(count_o[0]),
        .full(full_o[0]), .empty(empty_o[0]), .reject(reject_o[0]));
    digit_entry_reg #(.NUM_DIGITS(4), .DIGIT_W(4), .BCD_MODE(1'b0), .OVERWRITE(1'b0), .EDGE_DET(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clr(clr), .load(load),
        .digit_in(digit_in), .load_val(load_val), .dato(dato_o[1]), .count(count_o[1]),
        .full(full_o[1]), .empty(empty_o[1]), .reject(reject_o[1]));
    digit_entry_reg #(.NUM_DIGITS(4), .DIGIT_W(4), .BCD_MODE(1'b1), .OVERWRITE(1'b1), .EDGE_DET(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clr(clr), .load(load),
        .digit_in(digit_in), .load_val(load_val), .dato(dato_o[2]), .count(count_o[2]),
        .full(full_o[2]), .empty(empty_o[2]), .reject(reject_o[2]));
    digit_entry_reg #(.NUM_DIGITS(4), .DIGIT_W(4), .BCD_MODE(1'b0), .OVERWRITE(1'b1), .EDGE_DET(1'b0)) u_dut3 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clr(clr), .load(load),
        .digit_in(digit_in), .load_val(load_val), .dato(dato_o[3]), .count(count_o[3]),
        .full(full_o[3]), .empty(empty_o[3]), .reject(reject_o[3]));

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            logic exp_full, exp_empty;
            e = sb.pop_front();
            exp_full  = (e.count == 3'd4);
            exp_empty = (e.count == 3'd0);
            n_vec++;
            if (e.tag != cyc) begin
                n_err++;
                $display("FAIL vec%0d dut%0d: expectation for cycle %0d not checked in time (now %0d)",
                         e.id, e.dut, e.tag, cyc);
            end else if (dato_o[e.dut] !== e.dato || count_o[e.dut] !== e.count ||
                         full_o[e.dut] !== exp_full || empty_o[e.dut] !== exp_empty ||
                         reject_o[e.dut] !== e.reject) begin
                n_err++;
                $display("FAIL vec%0d dut%0d: got dato=%h count=%0d full=%b empty=%b reject=%b, want dato=%h count=%0d full=%b empty=%b reject=%b",
                         e.id, e.dut, dato_o[e.dut], count_o[e.dut], full_o[e.dut], empty_o[e.dut],
                         reject_o[e.dut], e.dato, e.count, exp_full, exp_empty, e.reject);
            end
        end
    end

    int vid = 0;

    task automatic drv(input logic r, input logic c, input logic l, input logic p,
                       input logic po, input logic [3:0] d, input logic [15:0] lv);
        @(negedge clk);
        rst = r; clr = c; load = l; push = p; pop = po; digit_in = d; load_val = lv;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    endtask

    // Expectation for the outputs after the upcoming clock edge.
    task automatic expect_next(input int dut, input logic [15:0] d, input logic [2:0] c, input logic rj);
        exp_t x;
        x.tag = cyc + 1; x.dut = dut; x.id = vid++; x.dato = d; x.count = c; x.reject = rj;
        sb.push_back(x);
    endtask

    task automatic press(input logic [3:0] d);
        drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, d, 16'h0);
    endtask

    task automatic reset_all();
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
        for (int i = 0; i < 4; i++) expect_next(i, 16'h0000, 3'd0, 1'b0);
        idle();
    endtask

    initial begin
        // Entry, saturation with and without overwrite
        reset_all();
        press(4'h1); expect_next(0, 16'h0001, 3'd1, 1'b0); idle();
        press(4'h2); idle();
        press(4'h3); idle();
        press(4'h4); expect_next(0, 16'h1234, 3'd4, 1'b0); expect_next(1, 16'h1234, 3'd4, 1'b0);
        idle();
        press(4'h5);
        expect_next(0, 16'h2345, 3'd4, 1'b0);
        expect_next(1, 16'h1234, 3'd4, 1'b1);
        expect_next(2, 16'h2345, 3'd4, 1'b0);
        expect_next(3, 16'h2345, 3'd4, 1'b0);
        idle(); expect_next(1, 16'h1234, 3'd4, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0);
        expect_next(1, 16'h0123, 3'd3, 1'b0);
        expect_next(0, 16'h0234, 3'd3, 1'b0);
        idle();

        // BCD rejection
        reset_all();
        press(4'hA);
        expect_next(2, 16'h0000, 3'd0, 1'b1);
        expect_next(0, 16'h000A, 3'd1, 1'b0);
        idle(); expect_next(2, 16'h0000, 3'd0, 1'b0);
        press(4'h7);
        expect_next(2, 16'h0007, 3'd1, 1'b0);
        expect_next(0, 16'h00A7, 3'd2, 1'b0);
        idle();

        // Held push: one event with edge detect, one per cycle without
        reset_all();
        press(4'h3); expect_next(0, 16'h0003, 3'd1, 1'b0); expect_next(3, 16'h0003, 3'd1, 1'b0);
        for (int i = 0; i < 8; i++) press(4'h3);
        press(4'h3); expect_next(0, 16'h0003, 3'd1, 1'b0); expect_next(3, 16'h3333, 3'd4, 1'b0);
        idle();

        // Pop empty, push+pop collision, load beats push
        reset_all();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0);
        expect_next(0, 16'h0000, 3'd0, 1'b1);
        idle(); expect_next(0, 16'h0000, 3'd0, 1'b0);
        press(4'h5); idle(); expect_next(0, 16'h0005, 3'd1, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h6, 16'h0);
        expect_next(0, 16'h0005, 3'd1, 1'b1);
        idle();
        drv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 16'hBEEF);
        expect_next(0, 16'hBEEF, 3'd4, 1'b0);
        expect_next(3, 16'hBEEF, 3'd4, 1'b0);
        idle();

        // Reset mid-entry and mid-hold, then clear with pop
        reset_all();
        press(4'h1); idle(); press(4'h2); idle();
        expect_next(0, 16'h0012, 3'd2, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 16'h0);
        expect_next(0, 16'h0000, 3'd0, 1'b0);
        press(4'h3); expect_next(0, 16'h0003, 3'd1, 1'b0);
        press(4'h3); expect_next(0, 16'h0003, 3'd1, 1'b0);
        idle();
        drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0);
        expect_next(0, 16'h0000, 3'd0, 1'b0);
        expect_next(1, 16'h0000, 3'd0, 1'b0);
        idle();

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/digit_entry_reg.md
Name: digit_entry_reg

Overview:
- Parametrised digit-entry register for keypad/button-driven numeric input. Successor to the fixed 16-bit, 4-bit-per-press shifter.
- Holds NUM_DIGITS digits of DIGIT_W bits and shifts a new digit in at the least-significant end on each accepted push.
- Adds backspace, clear, parallel load, a valid-digit count, full/empty flags, an optional BCD digit check, and optional rising-edge detection on the push/pop inputs.
- Sits between the debounced button/switch logic and the display or arithmetic datapath.

Parameters:
- NUM_DIGITS, 4, number of digit slots held.
- DIGIT_W, 4, bits per digit.
- BCD_MODE, 0, 1 = reject digit_in values greater than 9.
- OVERWRITE, 1, 1 = a push when full discards the most-significant digit; 0 = a push when full is rejected.
- EDGE_DET, 1, 1 = push and pop act on their rising edge; 0 = push and pop are treated as single-cycle strobes.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset; synchronous, active-high.
- push, input, 1, shift digit_in in at the LS end.
- pop, input, 1, backspace: drop the LS digit (shift right, zero-fill the MS end).
- clr, input, 1, clear all digits.
- load, input, 1, parallel load of load_val.
- digit_in, input, DIGIT_W, digit to push.
- load_val, input, NUM_DIGITS*DIGIT_W, value for load.
- dato, output, NUM_DIGITS*DIGIT_W, held value; digit 0 is in the LS bits.
- count, output, $clog2(NUM_DIGITS+1), number of digits entered.
- full, output, 1, count == NUM_DIGITS.
- empty, output, 1, count == 0.
- reject, output, 1, one-cycle pulse when a request is refused.

Behaviour:
- Reset (rst high at a clk edge):
  - dato = 0, count = 0, empty = 1, full = 0, reject = 0.
  - Edge-detector history flops = 0.
- All outputs are registered. An accepted event is visible on the outputs the cycle after the edge that samples it.
- Event generation:
  - EDGE_DET=1: push_ev = push & ~push_q, and likewise for pop. Holding an input high gives exactly one event.
  - EDGE_DET=0: push_ev = push, pop_ev = pop; each cycle high is one event.
- Priority per cycle: rst > clr > load > push_ev/pop_ev.
  - clr: dato = 0, count = 0. Any push/pop event in the same cycle is dropped silently; no reject.
  - load: dato = load_val, count = NUM_DIGITS. A same-cycle push/pop is dropped silently.
- Push (push_ev and no pop_ev):
  - If BCD_MODE=1 and digit_in > 9: reject, no state change.
  - Else if not full: dato = {dato[MS-DIGIT_W:0], digit_in}, count + 1.
  - Else if full and OVERWRITE=1: same shift, MS digit is lost, count stays NUM_DIGITS.
  - Else (full and OVERWRITE=0): reject, no change.
- Pop (pop_ev and no push_ev):
  - If empty: reject, no change.
  - Else: dato = {DIGIT_W'0, dato[MS:DIGIT_W]}, count - 1.
- push_ev and pop_ev in the same cycle: reject, no change.
- reject is high for exactly one cycle per refused request, registered. It never asserts during rst.
- full and empty are derived from the registered count and are never both high (NUM_DIGITS >= 1).
- Reset mid-hold with EDGE_DET=1: the history is cleared, so a button still held after rst releases generates one push_ev on the first cycle out of reset.
- With NUM_DIGITS=1, push and pop still operate: push replaces the digit (when OVERWRITE=1), pop zeroes it.

Decomposition:
- Package digit_entry_pkg holds:
  - the BCD_MAX = 9 constant;
  - a function giving the count width for a given NUM_DIGITS.
- One sub-module, rise_edge_det: 1-bit synchronous rising-edge detector with rst.
  - Instantiated twice (push, pop) inside a generate on EDGE_DET.
  - Bypassed when EDGE_DET=0.

Test Plan:
- Defaults; push 1,2,3,4 as four separate presses -> dato = 16'h1234, count = 4, full = 1. Fifth push of 5 -> dato = 16'h2345, count = 4, reject = 0.
- OVERWRITE=0, full at 16'h1234; push 5 -> reject pulses for one cycle, dato unchanged. Then pop -> dato = 16'h0123, count = 3.
- BCD_MODE=1; push digit_in = 4'hA -> reject, count stays 0. Push 7 -> dato = 16'h0007, count = 1.
- EDGE_DET=1; hold push high for 10 cycles with digit_in = 3 -> exactly one shift, dato = 16'h0003. Same test with EDGE_DET=0 -> count saturates at 4, dato = 16'h3333.
- Pop while empty -> reject, dato = 0. Push and pop in the same cycle -> reject, no change. Load 16'hBEEF together with push -> dato = 16'hBEEF, count = 4, no reject.
- Reset and clear:
  - rst asserted mid-entry (dato = 16'h0012) -> next cycle dato = 0, count = 0, empty = 1.
  - clr together with pop -> dato = 0, no reject.
